ps2_event_fifo: RTL and testbench

PS2_EVENT_FIFO -- requirements
Module: ps2_event_fifo

---
 rtl/ps2_event_fifo.sv | 197 +++++++++++++++++++
 tb/tb_ps2_event_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_event_fifo.sv
// PS/2 keyboard receiver with glitch-filtered clock, framing/parity/timeout
// checking, E0/F0 prefix decoding and a first-word-fall-through event FIFO.
module ps2_event_fifo #(
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 12000,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              res,
  input  logic              kbd_clk,
  input  logic              kbd_dat,
  input  logic              rd,
  input  logic              clr,
  output logic              ev_valid,
  output logic [7:0]        ev_code,
  output logic              ev_ext,
  output logic              ev_rel,
  output logic [ADDR_W:0]   ev_count,
  output logic              ovf,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Input synchronisers and clock filter
  logic [1:0]          clk_sync;
  logic [1:0]          dat_sync;
  logic [FILT_LEN-1:0] filt;
  logic                filt_level;
  logic                filt_prev;
  logic                fall;
  logic                dat_s;

  // Receiver state
  state_t              state;
  logic [2:0]          bit_cnt;
  logic [7:0]          shift;
  logic                par_bit;
  logic [TO_W-1:0]     to_cnt;
  logic                ext_flag;
  logic                rel_flag;
  logic                push;
  logic [9:0]          push_word;

  // Event FIFO
  logic [9:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                full;
  logic                pop;
  logic                wr_en;

  assign dat_s = dat_sync[1];
  assign fall  = filt_prev & ~filt_level;

  // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], kbd_clk};
      dat_sync <= {dat_sync[0], kbd_dat};
    end
  end

  // Glitch filter: level only changes once FILT_LEN samples agree
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      filt       <= '1;
      filt_level <= 1'b1;
      filt_prev  <= 1'b1;
    end else begin
      filt <= {filt[FILT_LEN-2:0], clk_sync[1]};
      if (&filt)
        filt_level <= 1'b1;
      else if (~|filt)
        filt_level <= 1'b0;
      filt_prev <= filt_level;
    end
  end

  // Frame receiver: bit sampling, checking, timeout and prefix decoding
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      ext_flag  <= 1'b0;
      rel_flag  <= 1'b0;
      push      <= 1'b0;
      push_word <= '0;
      err       <= 1'b0;
    end else begin
      push <= 1'b0;
      if (clr)
        err <= 1'b0;

      if (state == IDLE || fall)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TO_W'(1);

      if (state != IDLE && to_cnt == TO_W'(TIMEOUT)) begin
        // Keyboard stalled mid-frame: abandon it and any pending prefix
        state    <= IDLE;
        err      <= 1'b1;
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
        to_cnt   <= '0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {dat_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_s;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s && (^{shift, par_bit})) begin
              if (shift == 8'hE0) begin
                ext_flag <= 1'b1;
              end else if (shift == 8'hF0) begin
                rel_flag <= 1'b1;
              end else begin
                push      <= 1'b1;
                push_word <= {rel_flag, ext_flag, shift};
                ext_flag  <= 1'b0;
                rel_flag  <= 1'b0;
              end
            end else begin
              err      <= 1'b1;
              ext_flag <= 1'b0;
              rel_flag <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign ev_valid = (ev_count != '0);
  assign full     = (ev_count == (ADDR_W+1)'(DEPTH));
  assign pop      = rd & ev_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en    = push & (~full | pop);

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      ovf      <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_en, pop})
        2'b10:   ev_count <= ev_count + (ADDR_W+1)'(1);
        2'b01:   ev_count <= ev_count - (ADDR_W+1)'(1);
        default: ev_count <= ev_count;
      endcase
      if (push && full && !pop)
        ovf <= 1'b1;
      else if (clr)
        ovf <= 1'b0;
    end
  end

  // Event storage; contents need no reset since ev_count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= push_word;
  end

  assign {ev_rel, ev_ext, ev_code} = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_event_fifo.sv
// Randomised and directed bench for ps2_event_fifo against a queue-based model.
module tb_ps2_event_fifo;

  localparam int FILT_LEN = 4;
  localparam int TIMEOUT  = 500;
  localparam int ADDR_W   = 3;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int HALF     = 20;

  logic              clk = 1'b0;
  logic              res = 1'b1;
  logic              kbd_clk = 1'b1;
  logic              kbd_dat = 1'b1;
  logic              rd = 1'b0;
  logic              clr = 1'b0;
  logic              ev_valid;
  logic [7:0]        ev_code;
  logic              ev_ext;
  logic              ev_rel;
  logic [ADDR_W:0]   ev_count;
  logic              ovf;
  logic              err;

  ps2_event_fifo #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .res(res), .kbd_clk(kbd_clk), .kbd_dat(kbd_dat), .rd(rd), .clr(clr),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_rel(ev_rel),
    .ev_count(ev_count), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of {rel, ext, code} plus prefix and sticky flags
  logic [9:0] q[$];
  bit m_ext, m_rel, m_err, m_ovf;
  logic stop_v1, stop_v2;
  bit stop_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, ev_valid, (q.size() != 0));
    check({tag, ".count"}, ev_count, q.size());
    check({tag, ".ovf"}, ovf, m_ovf);
    check({tag, ".err"}, err, m_err);
    if (q.size() != 0)
      check({tag, ".head"}, {ev_rel, ev_ext, ev_code}, q[0]);
  endtask

  task automatic pop_one(input string tag);
    check_state(tag);
    $display("pop   %s head=%03h count=%0d", tag, {ev_rel, ev_ext, ev_code}, ev_count);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    if (q.size() != 0)
      void'(q.pop_front());
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_err = 1'b0;
    m_ovf = 1'b0;
    $display("clr");
  endtask

  // Send nbits of a frame (11 = complete). Optionally pulses rd on the cycle
  // the pushed event would be written, and records ev_valid 1 and 2 cycles
  // after the stop-bit edge.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input bit simul_rd, input int nbits);
    logic [10:0] bits;
    int ph;
    bit accept;
    ph = 0;
    stop_seen = 1'b0;
    stop_v1 = 1'bx;
    stop_v2 = 1'bx;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kbd_dat = bits[i];
      for (int c = 0; c < HALF; c++) begin
        kbd_clk = (glitch && c == HALF/2) ? 1'b0 : 1'b1;
        @(negedge clk);
      end
      for (int c = 0; c < HALF; c++) begin
        kbd_clk = (glitch && c == HALF/2) ? 1'b1 : 1'b0;
        @(negedge clk);
        if (i == 10) begin
          if (ph == 0 && dut.fall) begin
            ph = 1;
            stop_seen = 1'b1;
          end else if (ph == 1) begin
            stop_v1 = ev_valid;
            rd = simul_rd;
            ph = 2;
          end else if (ph == 2) begin
            stop_v2 = ev_valid;
            rd = 1'b0;
            ph = 3;
          end
        end
      end
    end
    kbd_clk = 1'b1;
    kbd_dat = 1'b1;
    rd = 1'b0;
    repeat (10) @(negedge clk);
    $display("frame %02h bits=%0d par_bad=%0d stop_bad=%0d glitch=%0d rd=%0d",
             b, nbits, bad_par, bad_stop, glitch, simul_rd);
    if (nbits == 11) begin
      check("stop_edge", stop_seen, 1'b1);
      if (simul_rd && q.size() != 0)
        void'(q.pop_front());
      accept = !bad_par && !bad_stop;
      if (!accept) begin
        m_err = 1'b1;
        m_ext = 1'b0;
        m_rel = 1'b0;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (b == 8'hF0) begin
        m_rel = 1'b1;
      end else begin
        if (q.size() == DEPTH)
          m_ovf = 1'b1;
        else
          q.push_back({m_rel, m_ext, b});
        m_ext = 1'b0;
        m_rel = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    res = 1'b1;
    q.delete();
    m_ext = 1'b0;
    m_rel = 1'b0;
    m_err = 1'b0;
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check_state("in_reset");
    res = 1'b0;
    repeat (3) @(negedge clk);
    $display("reset");
  endtask

  initial begin
    logic [7:0] rb;
    int r;
    bit bp, bs, gl;

    // Power-on reset
    apply_reset();
    check_state("after_reset");

    // Single good frame, latency into empty FIFO, then pop
    send_frame(8'h1C, 0, 0, 0, 0, 11);
    check("lat_v1", stop_v1, 1'b0);
    check("lat_v2", stop_v2, 1'b1);
    check("code_1c", ev_code, 8'h1C);
    pop_one("single");
    check_state("single_empty");

    // rd while empty is ignored
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check_state("rd_empty");

    // E0 F0 75 produces one extended release event
    send_frame(8'hE0, 0, 0, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 0, 0, 11);
    check("prefix_count", ev_count, 0);
    send_frame(8'h75, 0, 0, 0, 0, 11);
    check("ext_rel", {ev_rel, ev_ext, ev_code}, {2'b11, 8'h75});
    pop_one("prefix");
    check_state("prefix_empty");

    // Parity error then good byte
    send_frame(8'h1C, 1, 0, 0, 0, 11);
    send_frame(8'h1B, 0, 0, 0, 0, 11);
    check("parerr_err", err, 1'b1);
    pop_one("parerr");
    do_clr();
    check_state("parerr_clr");

    // Stalled frame times out, receiver recovers
    send_frame(8'h55, 0, 0, 0, 0, 5);
    repeat (TIMEOUT + 10) @(negedge clk);
    m_err = 1'b1;
    m_ext = 1'b0;
    m_rel = 1'b0;
    send_frame(8'h29, 0, 0, 0, 0, 11);
    check("timeout_err", err, 1'b1);
    pop_one("timeout");
    do_clr();

    // Overflow: DEPTH+1 frames, read back in order
    for (int i = 0; i <= DEPTH; i++)
      send_frame(8'h10 + 8'(i), 0, 0, 0, 0, 11);
    check("ovf_count", ev_count, DEPTH);
    check("ovf_flag", ovf, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      pop_one("ovf_drain");
    check_state("ovf_empty");
    do_clr();

    // Push with simultaneous pop while full: no overflow
    for (int i = 0; i < DEPTH; i++)
      send_frame(8'h40 + 8'(i), 0, 0, 0, 0, 11);
    send_frame(8'h4F, 0, 0, 0, 1, 11);
    check("full_rw_ovf", ovf, 1'b0);
    check("full_rw_count", ev_count, DEPTH);
    while (q.size() != 0)
      pop_one("full_rw_drain");

    // Glitches on kbd_clk inside a frame
    send_frame(8'hA5, 0, 0, 1, 0, 11);
    check("glitch_code", ev_code, 8'hA5);
    pop_one("glitch");

    // Reset mid-frame after a pending E0 prefix
    send_frame(8'hE0, 0, 0, 0, 0, 11);
    send_frame(8'h33, 0, 0, 0, 0, 6);
    apply_reset();
    send_frame(8'h5A, 0, 0, 0, 0, 11);
    check("rst_mid_ext", ev_ext, 1'b0);
    pop_one("rst_mid");

    // Randomised traffic
    for (int n = 0; n < 30; n++) begin
      r  = $urandom_range(0, 99);
      rb = 8'($urandom_range(0, 255));
      if (r < 10)
        rb = 8'hE0;
      else if (r < 18)
        rb = 8'hF0;
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 19) == 0);
      gl = ($urandom_range(0, 2) == 0);
      send_frame(rb, bp, bs, gl, 0, 11);
      check_state("rand");
      if ($urandom_range(0, 1) == 1)
        pop_one("rand_pop");
      if ($urandom_range(0, 7) == 0) begin
        do_clr();
        check_state("rand_clr");
      end
    end
    while (q.size() != 0)
      pop_one("final_drain");
    check_state("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
